// File: rtl/mdu_if.sv
// Execute-stage handshake bundle between the pipeline and the iterative MUL/DIV unit.
// The pipeline drives the instruction fields and operands; the unit returns decode, busy/done and result.
interface mdu_if #(
   parameter int XLEN = 32
);
   logic            valid;
   logic            flush;
   logic [6:0]      op;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] src_b;
   logic            is_m;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output valid, flush, op, funct3, funct7, src_a, src_b,
      input  is_m, busy, done, result
   );

   modport slave (
      input  valid, flush, op, funct3, funct7, src_a, src_b,
      output is_m, busy, done, result
   );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring shift-subtract step per cycle
// on operand magnitudes, sign fix-up on the final step, divide special cases resolved at accept.
module mdu_iterative #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input logic  clk,
   input logic  rst,
   mdu_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam logic [6:0]       OP_REG    = 7'b0110011;
   localparam logic [6:0]       F7_MULDIV = 7'b0000001;
   localparam logic [CNT_W-1:0] LAST      = CNT_W'(XLEN - 1);
   localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0]  ONES      = '1;

   state_t           state, state_next;
   logic [2:0]       f3;
   logic             neg;
   logic [XLEN-1:0]  hi, lo, opnd;
   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0]  result_q;

   logic             is_m, accept, is_div, a_signed, b_signed, sa, sb;
   logic             div_zero, div_ovf, special;
   logic [XLEN-1:0]  abs_a, abs_b, special_res;

   assign is_m     = (bus.op == OP_REG) && (bus.funct7 == F7_MULDIV);
   assign accept   = bus.valid && is_m && (state == IDLE) && !bus.flush;
   assign is_div   = bus.funct3[2];
   assign a_signed = bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
   assign b_signed = bus.funct3 inside {3'b000, 3'b001, 3'b100, 3'b110};
   assign sa       = a_signed && bus.src_a[XLEN-1];
   assign sb       = b_signed && bus.src_b[XLEN-1];
   assign abs_a    = sa ? -bus.src_a : bus.src_a;
   assign abs_b    = sb ? -bus.src_b : bus.src_b;

   // Signed overflow only exists for DIV/REM (funct3[0]==0 within the divide group).
   assign div_zero = (bus.src_b == '0);
   assign div_ovf  = !bus.funct3[0] && (bus.src_a == MIN_NEG) && (bus.src_b == ONES);
   assign special  = is_div && (div_zero || div_ovf);

   always_comb begin
      special_res = '0;
      if (div_zero)
         special_res = bus.funct3[1] ? bus.src_a : ONES;
      else
         special_res = bus.funct3[1] ? '0 : bus.src_a;
   end

   // One iteration: multiply uses {hi,lo} as product/multiplier, divide as remainder/dividend-quotient.
   logic [XLEN:0]   mul_sum, div_shift, div_diff;
   logic            div_ge;
   logic [XLEN-1:0] step_hi, step_lo;

   always_comb begin
      mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
      div_shift = {hi, lo[XLEN-1]};
      div_diff  = div_shift - {1'b0, opnd};
      div_ge    = !div_diff[XLEN];
      if (f3[2]) begin
         step_hi = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
         step_lo = {lo[XLEN-2:0], div_ge};
      end else begin
         step_hi = mul_sum[XLEN:1];
         step_lo = {mul_sum[0], lo[XLEN-1:1]};
      end
   end

   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo_s, rem_s, final_res;

   always_comb begin
      prod_s    = neg ? -{step_hi, step_lo} : {step_hi, step_lo};
      quo_s     = neg ? -step_lo : step_lo;
      rem_s     = neg ? -step_hi : step_hi;
      final_res = '0;
      case (f3)
         3'b000:                 final_res = prod_s[XLEN-1:0];
         3'b001, 3'b010, 3'b011: final_res = prod_s[2*XLEN-1:XLEN];
         3'b100, 3'b101:         final_res = quo_s;
         default:                final_res = rem_s;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = special ? DONE : CALC;
         CALC: begin
            if (bus.flush)        state_next = IDLE;
            else if (cnt == LAST) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f3       <= '0;
         neg      <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         opnd     <= '0;
         cnt      <= '0;
         result_q <= '0;
      end else if (accept) begin
         f3   <= bus.funct3;
         // Remainder takes the dividend's sign; products and quotients take sa^sb.
         neg  <= (is_div && bus.funct3[1]) ? sa : (sa ^ sb);
         cnt  <= '0;
         hi   <= '0;
         lo   <= is_div ? abs_a : abs_b;
         opnd <= is_div ? abs_b : abs_a;
         if (special) result_q <= special_res;
      end else if (state == CALC && !bus.flush) begin
         hi  <= step_hi;
         lo  <= step_lo;
         cnt <= cnt + 1'b1;
         if (cnt == LAST) result_q <= final_res;
      end
   end

   assign bus.is_m   = is_m;
   assign bus.busy   = (state != IDLE);
   assign bus.done   = (state == DONE) && !bus.flush;
   assign bus.result = result_q;
endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative: table of M-extension vectors with hand-computed results and
// latencies, then sequences for flush, reset, ignored valids and back-to-back issue.
module tb_mdu_iterative;
   localparam logic [6:0] OPC = 7'b0110011;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   localparam int NV = 22;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   done_cnt = 0;
   int   exp_dones = 0;

   mdu_if #(.XLEN(32)) bus ();

   mdu_iterative #(.XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      #1;
      if (bus.done === 1'b1) done_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic present(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      bus.valid  = 1'b1;
      bus.op     = OPC;
      bus.funct7 = 7'b0000001;
      bus.funct3 = f3;
      bus.src_a  = a;
      bus.src_b  = b;
   endtask

   // Called at a negedge: presents one op, then waits (bounded) for its done pulse.
   task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      output int lat, output int busy_cycles, output logic [31:0] res);
      present(f3, a, b);
      @(posedge clk);
      #1 bus.valid = 1'b0;
      lat = -1;
      busy_cycles = 0;
      res = '0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (bus.busy) busy_cycles++;
         if (bus.done) begin
            lat = k;
            res = bus.result;
            break;
         end
      end
   endtask

   vec_t        vecs [NV];
   int          lat, bcyc;
   logic [31:0] res;

   initial begin
      vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
      vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
      vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
      vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
      vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
      vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
      vecs[6]  = '{3'b101, 32'd100,       32'd7,         32'd14,        33};
      vecs[7]  = '{3'b111, 32'd100,       32'd7,         32'd2,         33};
      vecs[8]  = '{3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
      vecs[9]  = '{3'b110, 32'd5,         32'd0,         32'd5,         1};
      vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
      vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
      vecs[12] = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
      vecs[13] = '{3'b111, 32'd5,         32'd0,         32'd5,         1};
      vecs[14] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33};
      vecs[15] = '{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};
      vecs[16] = '{3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
      vecs[17] = '{3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         33};
      vecs[18] = '{3'b100, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         33};
      vecs[19] = '{3'b001, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33};
      vecs[20] = '{3'b011, 32'h0001_0000, 32'h0001_0000, 32'd1,         33};
      vecs[21] = '{3'b000, 32'h0001_0000, 32'h0001_0000, 32'd0,         33};

      bus.valid = 1'b0; bus.flush = 1'b0; bus.op = '0; bus.funct3 = '0;
      bus.funct7 = '0;  bus.src_a = '0;   bus.src_b = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset_busy", {31'd0, bus.busy}, 32'd0);
      chk("reset_done", {31'd0, bus.done}, 32'd0);
      chk("reset_result", bus.result, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Table vectors, each issued in the first IDLE cycle after the previous done
      for (int i = 0; i < NV; i++) begin
         run(vecs[i].f3, vecs[i].a, vecs[i].b, lat, bcyc, res);
         exp_dones++;
         $display("[TB] vec %0d f3=%0d a=%h b=%h -> result %h latency %0d", i, vecs[i].f3,
                  vecs[i].a, vecs[i].b, res, lat);
         chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
         chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
         chk($sformatf("vec%0d_busy_cycles", i), bcyc, vecs[i].lat);
         @(negedge clk);
         chk($sformatf("vec%0d_done_pulse", i), {30'd0, bus.done, bus.busy}, 32'd0);
      end

      // Flush during CALC cycle 10 of a DIVU
      present(3'b101, 32'd1000, 32'd3);
      @(posedge clk);
      #1 bus.valid = 1'b0;
      for (int k = 1; k <= 10; k++) @(negedge clk);
      chk("flush_calc_busy_before", {31'd0, bus.busy}, 32'd1);
      bus.flush = 1'b1;
      @(posedge clk);
      #1 bus.flush = 1'b0;
      @(negedge clk);
      chk("flush_calc_busy_after", {31'd0, bus.busy}, 32'd0);
      repeat (40) @(negedge clk);
      chk("flush_calc_result_held", bus.result, vecs[NV-1].exp);
      $display("[TB] flush in CALC: busy %0d result %h", bus.busy, bus.result);

      // Flush coinciding with the DONE cycle of a special case
      present(3'b100, 32'd5, 32'd0);
      @(posedge clk);
      #1 begin bus.valid = 1'b0; bus.flush = 1'b1; end
      @(negedge clk);
      chk("flush_done_suppressed", {31'd0, bus.done}, 32'd0);
      @(posedge clk);
      #1 bus.flush = 1'b0;
      @(negedge clk);
      chk("flush_done_idle", {31'd0, bus.busy}, 32'd0);
      $display("[TB] flush in DONE: busy %0d", bus.busy);

      // flush together with valid in IDLE: no accept
      present(3'b000, 32'd3, 32'd5);
      bus.flush = 1'b1;
      @(posedge clk);
      #1 begin bus.valid = 1'b0; bus.flush = 1'b0; end
      @(negedge clk);
      chk("flush_valid_no_accept", {31'd0, bus.busy}, 32'd0);

      // Non-M instructions are ignored
      present(3'b000, 32'd3, 32'd5);
      bus.funct7 = 7'b0000000;
      #1 chk("is_m_funct7_zero", {31'd0, bus.is_m}, 32'd0);
      @(posedge clk);
      #1 bus.valid = 1'b0;
      @(negedge clk);
      chk("non_m_no_accept", {31'd0, bus.busy}, 32'd0);
      present(3'b000, 32'd3, 32'd5);
      bus.op = 7'b0010011;
      #1 chk("is_m_other_opcode", {31'd0, bus.is_m}, 32'd0);
      bus.op = OPC;
      #1 chk("is_m_m_op", {31'd0, bus.is_m}, 32'd1);
      bus.valid = 1'b0;
      @(negedge clk);

      // valid while busy is ignored
      present(3'b000, 32'd3, 32'd5);
      @(posedge clk);
      #1 present(3'b101, 32'd5, 32'd0);
      repeat (5) @(negedge clk);
      bus.valid = 1'b0;
      exp_dones++;
      lat = -1; res = '0;
      for (int k = 6; k <= 60; k++) begin
         @(negedge clk);
         if (bus.done) begin
            lat = k;
            res = bus.result;
            break;
         end
      end
      chk("busy_valid_result", res, 32'd15);
      chk("busy_valid_latency", lat, 33);
      repeat (5) @(negedge clk);
      chk("busy_valid_no_second", {31'd0, bus.busy}, 32'd0);
      $display("[TB] valid during busy: result %h latency %0d", res, lat);

      // Asynchronous reset in the middle of a MUL
      present(3'b000, 32'd9, 32'd9);
      @(posedge clk);
      #1 bus.valid = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_mid_done", {31'd0, bus.done}, 32'd0);
      chk("rst_mid_result", bus.result, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("rst_no_late_done_busy", {31'd0, bus.busy}, 32'd0);
      $display("[TB] reset mid-MUL: busy %0d result %h", bus.busy, bus.result);

      chk("total_done_pulses", done_cnt, exp_dones);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Iterative RV32M multiply/divide unit for the execute stage; successor to the combinational ALU decoder.
- Self-decodes op/funct3/funct7 for the eight M-extension operations.
- Computes one result bit per cycle over a parametrised datapath width.
- Uses a valid/busy/done handshake so the hazard unit can stall the pipeline while the unit is busy.

Parameters:
- XLEN, 32, datapath width in bits; any even value ≥ 8.
- CNT_W, $clog2(XLEN)+1, iteration counter width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- valid  in  1  execute-stage instruction present this cycle
- flush  in  1  kill any in-flight operation (branch mispredict / exception)
- op  in  7  instruction opcode
- funct3  in  3  instruction funct3
- funct7  in  7  instruction funct7
- src_a  in  XLEN  rs1 operand: multiplicand / dividend
- src_b  in  XLEN  rs2 operand: multiplier / divisor
- is_m  out  1  combinational: op==7'b0110011 && funct7==7'b0000001
- busy  out  1  state != IDLE; drives the pipeline stall
- done  out  1  one-cycle pulse, result valid
- result  out  XLEN  registered result; holds until the next done

Behaviour:
- Reset: state=IDLE; busy=0, done=0, result=0; all internal registers cleared.
- Reset is asynchronous and may assert in any state; no done is produced for the aborted operation.
- Operation map by funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Accept condition: valid && is_m && state==IDLE && !flush, sampled at a rising edge.
  - Not is_m: valid is ignored.
  - valid while busy: ignored; the pipeline is stalled, so the same instruction is not re-presented as new.
- Accept latches:
  - the operation;
  - the operand magnitudes (two's-complement absolute value where the operand is treated as signed);
  - the result sign: product = sa^sb; quotient = sa^sb; remainder = sign of dividend;
  - counter=0.
- States:
  - IDLE: on accept go to CALC, or directly to DONE for a division special case.
  - CALC: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; counter increments; after XLEN steps go to DONE.
  - DONE: result register loaded and done=1 for exactly this cycle; next state IDLE. A new op may be accepted on the edge that leaves DONE only if busy has already fallen, so the earliest accept is the first IDLE cycle.
- Latency:
  - Normal operations: done high XLEN+1 cycles after the accept edge, i.e. in the cycle following XLEN CALC cycles.
  - Special cases: done high in the cycle immediately after the accept edge.
- Multiply:
  - 2*XLEN-bit unsigned product of the magnitudes; negated if the sign flag is set.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
  - MULHSU treats src_a as signed and src_b as unsigned.
- Divide:
  - Unsigned restoring division on the magnitudes, then sign fix-up.
  - DIVU/REMU never negate.
- Special cases, resolved at accept with no CALC cycles:
  - divisor==0: quotient = all ones; remainder = src_a.
  - Signed overflow (src_a = 1<<(XLEN-1), src_b = all ones, DIV/REM only): quotient = src_a; remainder = 0.
- Flush:
  - In CALC or DONE: return to IDLE next edge; done suppressed (forced 0 in a DONE cycle that coincides with flush); result not updated.
  - flush and valid in the same IDLE cycle: no accept.
- result changes only on the edge entering DONE.

Test Plan:
- XLEN=32, MUL src_a=7, src_b=0xFFFFFFFD -> done 33 cycles after accept, result=0xFFFFFFEB; busy high 33 cycles.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0; each with done on the cycle after accept.
- Start DIVU, assert flush at CALC cycle 10 -> busy=0 next cycle, no done pulse, result unchanged. Then assert rst mid-MUL -> all outputs 0 immediately.
- Assert valid for a non-M op (funct7=0) and valid during busy -> no accept, no extra done. Issue back-to-back ops -> exactly one done per accept.
